prism_sp_rx_dispatch: RTL and testbench
=======================================

// Module: prism_sp_rx_dispatch
// PURPOSE
// Upstream stage of the RX core array: receives the GEM RX beat stream (push-only, no backpressure)
// and steers each whole frame to one RX core. The frame goes into that core's data FIFO, and one
// status word per frame goes into that core's meta FIFO. Cores are chosen round-robin. A frame is
// admitted only if its core can hold a maximum-size frame; otherwise the whole frame is dropped.
// PARAMETERS
// NRXCORES        1    number of RX cores / FIFO pairs (1..8)
// DATA_WIDTH      64   beat width in bits; multiple of 8
// COUNT_WIDTH     12   width of each data-FIFO free-word count
// MAX_FRAME_WORDS 190  beats reserved per admitted frame (1518 B / 8, rounded up)
// META_WIDTH      32   meta word width
// PORTS
// clock            in   1                       single clock domain
// resetn           in   1                       async assert, active-low
// rx_valid         in   1                       beat present this cycle
// rx_data          in   DATA_WIDTH              beat payload
// rx_sop           in   1                       first beat of frame
// rx_eop           in   1                       last beat of frame
// rx_bytes         in   $clog2(DATA_WIDTH/8)    valid bytes in eop beat; 0 = all bytes valid
// rx_err           in   1                       MAC error (FCS/symbol); sampled with eop
// data_wr_en       out  NRXCORES                one-hot data FIFO write strobe
// data_wr_data     out  DATA_WIDTH              shared data bus to all data FIFOs
// data_free        in   NRXCORES*COUNT_WIDTH    per-core free words; slice i = core i
// meta_wr_en       out  NRXCORES                one-hot meta FIFO write strobe
// meta_wr_data     out  META_WIDTH              {err, trunc, 14'b0, len[15:0]}
// meta_full        in   NRXCORES                per-core meta FIFO full
// drop_irq         out  1                       1-cycle pulse per dropped frame
// BEHAVIOUR
// - Reset: every output 0, FSM = IDLE, rr_ptr = 0, counters 0.
// - FSM states: IDLE, STREAM, DISCARD.
// - IDLE
//   - Beat with rx_valid & rx_sop: tgt = rr_ptr.
//   - Admit when data_free[tgt] >= MAX_FRAME_WORDS and !meta_full[tgt].
//     - Admit: go to STREAM, write the beat.
//     - Otherwise: go to DISCARD, pulse drop_irq.
//   - rr_ptr advances (wraps at NRXCORES-1) on every sop, whether admitted or dropped.
//   - A beat without sop in IDLE is ignored.
// - STREAM: each rx_valid beat is written to FIFO tgt.
//   - len accumulates DATA_WIDTH/8 per beat, or rx_bytes on the eop beat.
// - DISCARD: beats are ignored until eop, then return to IDLE.
// - Latency
//   - data_wr_en/data_wr_data are registered: 1 cycle after the input beat.
//   - meta_wr_en pulses 1 cycle after the last data write (2 cycles after eop).
// - Single-beat frame (sop & eop together): admit check, one data write, one meta write.
// - Back-to-back frames: a sop in the cycle right after eop must be accepted. The previous meta
//   write and the new data write may occur in the same cycle, possibly to different cores.
// - Overlength frame
//   - After MAX_FRAME_WORDS written beats, further beats are not written.
//   - trunc = 1; len saturates at MAX_FRAME_WORDS*DATA_WIDTH/8.
// - sop arriving in STREAM (eop lost)
//   - The open frame is closed: meta with err = 1 and len so far.
//   - The new sop is handled as in IDLE in the same cycle.
// - len is 16 bits and saturates at 0xFFFF.
// - The admit check is made only at sop; free space is guaranteed by the MAX reservation.
// - An async reset mid-frame abandons the frame: no meta write is issued.
// CONFIGURATION
// PRISM_SP_RX_DISPATCH_STATS_EN
// - Defined
//   - Adds 32-bit counters per core: stat_frames[i] (admitted frames), stat_drops[i] (drops
//     charged to tgt).
//   - Read via out port stat_rd_data (32 bit); stat_rd_sel in, $clog2(2*NRXCORES) bits;
//     combinational read.
//   - Counters saturate at 0xFFFFFFFF and are cleared by resetn.
// - Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
// - NRXCORES=2: four 64 B frames with full space -> cores 0,1,0,1.
//   - Each core gets 8 data writes plus meta len=64, err=0.
// - data_free[1]=100, frames to cores 0,1 -> core 1 frame dropped, drop_irq 1 pulse.
//   - No writes to core 1; the next frame goes to core 0.
// - 61 B frame (8 beats, rx_bytes=5) with rx_err=1 on eop -> 8 data writes, meta 0x8000003D.
// - 200-beat frame -> 190 data writes, meta {err=0, trunc=1, len=1520}.
// - Frame A of 3 beats, eop lost, then sop of frame B -> A meta err=1 len=24; B stored normally.
// - resetn low mid-frame then frame C -> no meta for the partial frame; C goes to core 0, len correct.

Source files
------------

// File: rtl/prism_sp_rx_dispatch.sv
// RX beat dispatcher: steers whole frames round-robin into per-core data/meta FIFOs.
// Optional per-core frame/drop counters under PRISM_SP_RX_DISPATCH_STATS_EN.
module prism_sp_rx_dispatch #(
  parameter int NRXCORES        = 1,
  parameter int DATA_WIDTH      = 64,
  parameter int COUNT_WIDTH     = 12,
  parameter int MAX_FRAME_WORDS = 190,
  parameter int META_WIDTH      = 32
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            rx_valid,
  input  logic [DATA_WIDTH-1:0]           rx_data,
  input  logic                            rx_sop,
  input  logic                            rx_eop,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] rx_bytes,
  input  logic                            rx_err,
  output logic [NRXCORES-1:0]             data_wr_en,
  output logic [DATA_WIDTH-1:0]           data_wr_data,
  input  logic [NRXCORES*COUNT_WIDTH-1:0] data_free,
  output logic [NRXCORES-1:0]             meta_wr_en,
  output logic [META_WIDTH-1:0]           meta_wr_data,
  input  logic [NRXCORES-1:0]             meta_full,
  output logic                            drop_irq
`ifdef PRISM_SP_RX_DISPATCH_STATS_EN
  ,
  input  logic [$clog2(2*NRXCORES)-1:0]   stat_rd_sel,
  output logic [31:0]                     stat_rd_data
`endif
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int PW  = (NRXCORES > 1) ? $clog2(NRXCORES) : 1;
  localparam int WW  = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [COUNT_WIDTH-1:0] MAXF = COUNT_WIDTH'(MAX_FRAME_WORDS);
  localparam logic [WW-1:0] MAXW = WW'(MAX_FRAME_WORDS);
  localparam logic [PW-1:0] LASTP = PW'(NRXCORES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DISCARD} state_e;

  state_e                  state_q;
  logic [PW-1:0]           rr_q, tgt_q, mtgt_q;
  logic [WW-1:0]           cnt_q;
  logic [15:0]             len_q;
  logic                    trunc_q, pend_q, drop_q;
  logic [META_WIDTH-1:0]   pword_q, meta_wr_data_q;
  logic [NRXCORES-1:0]     data_wr_en_q, meta_wr_en_q;
  logic [DATA_WIDTH-1:0]   data_wr_data_q;

  logic                    sop_go, admit, beat_wr, trunc_d;
  logic [COUNT_WIDTH-1:0]  free_sel;
  logic [NRXCORES-1:0]     rr_oh;
  logic [15:0]             beat_bytes, len_d;
  logic [16:0]             len_sum;
  logic [PW-1:0]           rr_d;

  function automatic logic [NRXCORES-1:0] oh(input logic [PW-1:0] i);
    oh = NRXCORES'(1) << i;
  endfunction

  function automatic logic [META_WIDTH-1:0] meta_word(
    input logic e, input logic t, input logic [15:0] l);
    meta_word = '0;
    meta_word[META_WIDTH-1] = e;
    meta_word[META_WIDTH-2] = t;
    meta_word[15:0] = l;
  endfunction

  always_comb begin
    rr_oh      = oh(rr_q);
    free_sel   = data_free[int'(rr_q)*COUNT_WIDTH +: COUNT_WIDTH];
    sop_go     = rx_valid & rx_sop & (state_q != DISCARD);
    admit      = (free_sel >= MAXF) & ~|(meta_full & rr_oh);
    beat_bytes = (rx_eop && rx_bytes != '0) ? 16'(rx_bytes) : 16'(BPB);
    len_sum    = {1'b0, len_q} + {1'b0, beat_bytes};
    beat_wr    = cnt_q < MAXW;
    len_d      = len_q;
    if (beat_wr) len_d = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    trunc_d    = trunc_q | ~beat_wr;
    rr_d       = (rr_q == LASTP) ? '0 : rr_q + PW'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      tgt_q          <= '0;
      mtgt_q         <= '0;
      cnt_q          <= '0;
      len_q          <= '0;
      trunc_q        <= 1'b0;
      pend_q         <= 1'b0;
      drop_q         <= 1'b0;
      pword_q        <= '0;
      meta_wr_data_q <= '0;
      data_wr_en_q   <= '0;
      meta_wr_en_q   <= '0;
      data_wr_data_q <= '0;
    end else begin
      data_wr_en_q <= '0;
      meta_wr_en_q <= '0;
      drop_q       <= 1'b0;
      pend_q       <= 1'b0;
      if (pend_q) begin
        meta_wr_en_q   <= oh(mtgt_q);
        meta_wr_data_q <= pword_q;
      end
      // A sop while streaming closes the open frame immediately as errored
      if (sop_go && state_q == STREAM) begin
        meta_wr_en_q   <= oh(tgt_q);
        meta_wr_data_q <= meta_word(1'b1, trunc_q, len_q);
      end
      if (sop_go) begin
        rr_q    <= rr_d;
        tgt_q   <= rr_q;
        cnt_q   <= WW'(1);
        len_q   <= beat_bytes;
        trunc_q <= 1'b0;
        if (admit) begin
          data_wr_en_q   <= rr_oh;
          data_wr_data_q <= rx_data;
          state_q        <= rx_eop ? IDLE : STREAM;
          if (rx_eop) begin
            pend_q  <= 1'b1;
            mtgt_q  <= rr_q;
            pword_q <= meta_word(rx_err, 1'b0, beat_bytes);
          end
        end else begin
          drop_q  <= 1'b1;
          state_q <= rx_eop ? IDLE : DISCARD;
        end
      end else if (rx_valid) begin
        unique case (state_q)
          STREAM: begin
            if (beat_wr) begin
              data_wr_en_q   <= oh(tgt_q);
              data_wr_data_q <= rx_data;
              cnt_q          <= cnt_q + WW'(1);
            end
            len_q   <= len_d;
            trunc_q <= trunc_d;
            if (rx_eop) begin
              pend_q  <= 1'b1;
              mtgt_q  <= tgt_q;
              pword_q <= meta_word(rx_err, trunc_d, len_d);
              state_q <= IDLE;
            end
          end
          DISCARD: if (rx_eop) state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign data_wr_en   = data_wr_en_q;
  assign data_wr_data = data_wr_data_q;
  assign meta_wr_en   = meta_wr_en_q;
  assign meta_wr_data = meta_wr_data_q;
  assign drop_irq     = drop_q;

`ifdef PRISM_SP_RX_DISPATCH_STATS_EN
  localparam int SW = $clog2(2*NRXCORES);
  logic [31:0] frames_q [NRXCORES];
  logic [31:0] drops_q  [NRXCORES];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NRXCORES; i++) begin
        frames_q[i] <= '0;
        drops_q[i]  <= '0;
      end
    end else if (sop_go) begin
      for (int i = 0; i < NRXCORES; i++) begin
        if (rr_q == PW'(i)) begin
          if (admit && frames_q[i] != '1) frames_q[i] <= frames_q[i] + 32'd1;
          if (!admit && drops_q[i] != '1) drops_q[i] <= drops_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_rd_data = '0;
    for (int i = 0; i < NRXCORES; i++) begin
      if (stat_rd_sel == SW'(i)) stat_rd_data = frames_q[i];
      if (stat_rd_sel == SW'(i + NRXCORES)) stat_rd_data = drops_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_prism_sp_rx_dispatch.sv
// Bench for prism_sp_rx_dispatch: directed frame table, corner sequences,
// randomized frames checked against a frame-level reference model.
module tb_prism_sp_rx_dispatch;
  localparam int N  = 2;
  localparam int DW = 64;
  localparam int CW = 12;
  localparam int MW = 32;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [2:0]    rx_bytes = '0;
  logic [N-1:0]  data_wr_en, meta_wr_en;
  logic [N-1:0]  meta_full = '0;
  logic [DW-1:0] data_wr_data;
  logic [N*CW-1:0] data_free = '0;
  logic [MW-1:0] meta_wr_data;
  logic          drop_irq;
`ifdef PRISM_SP_RX_DISPATCH_STATS_EN
  logic [1:0]    stat_rd_sel = '0;
  logic [31:0]   stat_rd_data;
`endif

  prism_sp_rx_dispatch #(
    .NRXCORES(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW),
    .MAX_FRAME_WORDS(190), .META_WIDTH(MW)
  ) dut (
    .clock(clock), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_bytes(rx_bytes), .rx_err(rx_err),
    .data_wr_en(data_wr_en), .data_wr_data(data_wr_data),
    .data_free(data_free),
    .meta_wr_en(meta_wr_en), .meta_wr_data(meta_wr_data),
    .meta_full(meta_full), .drop_irq(drop_irq)
`ifdef PRISM_SP_RX_DISPATCH_STATS_EN
    , .stat_rd_sel(stat_rd_sel), .stat_rd_data(stat_rd_data)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int core; logic [63:0] val; } wr_t;
  typedef struct {
    int nb; int bytes; bit err; int f0; int f1; logic [1:0] mf;
    int core; bit drop; int nwr; logic [31:0] meta;
  } vec_t;

  wr_t dq[$], mq[$], ed[$], em[$];
  logic [63:0] txd[$];
  vec_t tv[$];
  int drops, onehot_bad, checks, failures;

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (data_wr_en[i]) dq.push_back('{i, data_wr_data});
      if (meta_wr_en[i]) mq.push_back('{i, 64'(meta_wr_data)});
    end
    if ($countones(data_wr_en) > 1 || $countones(meta_wr_en) > 1)
      onehot_bad++;
    if (drop_irq) drops++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_free(input int f0, input int f1);
    data_free = {CW'(f1), CW'(f0)};
  endtask

  task automatic clr();
    dq.delete();
    mq.delete();
    txd.delete();
    drops = 0;
  endtask

  task automatic do_reset();
    rx_valid = 0; rx_sop = 0; rx_eop = 0;
    resetn = 0;
    idle(2);
    resetn = 1;
    idle(1);
  endtask

  task automatic send_frame(input int nb, input int bytes,
                            input bit err, input bit eop_en);
    logic [63:0] d;
    for (int b = 0; b < nb; b++) begin
      d = {$urandom, $urandom};
      rx_valid = 1;
      rx_sop   = (b == 0);
      rx_eop   = eop_en && (b == nb - 1);
      rx_data  = d;
      rx_bytes = rx_eop ? 3'(bytes) : 3'($urandom);
      rx_err   = rx_eop ? err : 1'($urandom);
      txd.push_back(d);
      @(posedge clock);
      #1;
    end
    rx_valid = 0; rx_sop = 0; rx_eop = 0;
  endtask

  int rr_m, edrops;
  task automatic model_frame(input int base, input int nb, input int bytes,
                             input bit err, input int f0, input int f1,
                             input logic [1:0] mf);
    int tgt, fr, nw, len;
    logic [31:0] w;
    tgt  = rr_m;
    rr_m = (rr_m + 1) % N;
    fr   = (tgt == 0) ? f0 : f1;
    if (fr >= 190 && !mf[tgt]) begin
      nw  = (nb > 190) ? 190 : nb;
      len = 0;
      for (int b = 0; b < nw; b++) begin
        ed.push_back('{tgt, txd[base + b]});
        len += (b == nb - 1 && bytes != 0) ? bytes : 8;
      end
      w = {err, (nb > 190), 14'b0, 16'(len)};
      em.push_back('{tgt, 64'(w)});
    end else begin
      edrops++;
    end
  endtask

  initial begin
    bit ok;
    int nb, bytes, base, f0, f1;
    bit err;
    logic [1:0] mf;
    checks = 0; failures = 0; onehot_bad = 0;
    set_free(300, 300);

    idle(2);
    @(negedge clock);
    chk("rst_data_wr_en", data_wr_en, 0);
    chk("rst_meta_wr_en", meta_wr_en, 0);
    chk("rst_drop_irq", drop_irq, 0);
    chk("rst_data", data_wr_data, 0);
    chk("rst_meta", meta_wr_data, 0);
    @(posedge clock);
    #1;
    resetn = 1;
    idle(1);

    tv.push_back('{8, 0, 0, 300, 300, 2'b00, 0, 0, 8, 32'h40});
    tv.push_back('{8, 0, 0, 300, 300, 2'b00, 1, 0, 8, 32'h40});
    tv.push_back('{8, 0, 0, 300, 300, 2'b00, 0, 0, 8, 32'h40});
    tv.push_back('{8, 0, 0, 300, 300, 2'b00, 1, 0, 8, 32'h40});
    tv.push_back('{8, 0, 0, 300, 100, 2'b00, 0, 0, 8, 32'h40});
    tv.push_back('{8, 0, 0, 300, 100, 2'b00, 1, 1, 0, 32'h0});
    tv.push_back('{8, 5, 1, 300, 300, 2'b00, 0, 0, 8, 32'h8000003D});
    tv.push_back('{200, 0, 0, 300, 300, 2'b00, 1, 0, 190, 32'h400005F0});
    tv.push_back('{1, 3, 0, 300, 300, 2'b00, 0, 0, 1, 32'h3});
    tv.push_back('{4, 0, 0, 300, 300, 2'b10, 1, 1, 0, 32'h0});
    tv.push_back('{3, 0, 0, 190, 300, 2'b00, 0, 0, 3, 32'h18});
    tv.push_back('{3, 0, 0, 300, 189, 2'b00, 1, 1, 0, 32'h0});
    tv.push_back('{2, 7, 1, 300, 300, 2'b00, 0, 0, 2, 32'h8000000F});
    tv.push_back('{1, 0, 0, 300, 300, 2'b00, 1, 0, 1, 32'h8});

    for (int k = 0; k < tv.size(); k++) begin
      set_free(tv[k].f0, tv[k].f1);
      meta_full = tv[k].mf;
      clr();
      send_frame(tv[k].nb, tv[k].bytes, tv[k].err, 1'b1);
      idle(4);
      chk($sformatf("v%0d_ndata", k), dq.size(), tv[k].nwr);
      if (tv[k].nwr > 0) begin
        ok = 1;
        for (int j = 0; j < dq.size(); j++)
          if (dq[j].core != tv[k].core || dq[j].val !== txd[j]) ok = 0;
        chk($sformatf("v%0d_data", k), ok, 1);
      end
      chk($sformatf("v%0d_nmeta", k), mq.size(), tv[k].drop ? 0 : 1);
      if (!tv[k].drop && mq.size() == 1) begin
        chk($sformatf("v%0d_meta", k), mq[0].val, tv[k].meta);
        chk($sformatf("v%0d_mcore", k), mq[0].core, tv[k].core);
      end
      chk($sformatf("v%0d_drop", k), drops, tv[k].drop);
    end
    meta_full = '0;
    set_free(300, 300);

    do_reset();
    clr();
    send_frame(3, 0, 0, 1'b0);
    send_frame(4, 0, 0, 1'b1);
    idle(4);
    chk("lost_ndata", dq.size(), 7);
    ok = (dq.size() == 7);
    for (int j = 0; j < dq.size() && j < 7; j++)
      if (dq[j].core != (j < 3 ? 0 : 1) || dq[j].val !== txd[j]) ok = 0;
    chk("lost_data", ok, 1);
    chk("lost_nmeta", mq.size(), 2);
    if (mq.size() == 2) begin
      chk("lost_metaA", mq[0].val, 64'h80000018);
      chk("lost_coreA", mq[0].core, 0);
      chk("lost_metaB", mq[1].val, 64'h20);
      chk("lost_coreB", mq[1].core, 1);
    end

    do_reset();
    clr();
    send_frame(3, 0, 0, 1'b0);
    resetn = 0;
    idle(2);
    chk("rst_mid_nmeta", mq.size(), 0);
    resetn = 1;
    idle(1);
    clr();
    send_frame(6, 2, 0, 1'b1);
    idle(4);
    chk("rstC_ndata", dq.size(), 6);
    ok = 1;
    for (int j = 0; j < dq.size(); j++)
      if (dq[j].core != 0 || dq[j].val !== txd[j]) ok = 0;
    chk("rstC_data", ok, 1);
    chk("rstC_nmeta", mq.size(), 1);
    if (mq.size() == 1) begin
      chk("rstC_meta", mq[0].val, 64'h2A);
      chk("rstC_core", mq[0].core, 0);
    end

    do_reset();
    clr();
    send_frame(4, 0, 0, 1'b1);
    send_frame(1, 5, 0, 1'b1);
    send_frame(3, 1, 0, 1'b1);
    idle(4);
    chk("b2b_ndata", dq.size(), 8);
    ok = (dq.size() == 8);
    for (int j = 0; j < dq.size() && j < 8; j++)
      if (dq[j].core != (j == 4 ? 1 : 0) || dq[j].val !== txd[j]) ok = 0;
    chk("b2b_data", ok, 1);
    chk("b2b_nmeta", mq.size(), 3);
    if (mq.size() == 3) begin
      chk("b2b_m0", {mq[0].core[7:0], mq[0].val[31:0]}, {8'd0, 32'h20});
      chk("b2b_m1", {mq[1].core[7:0], mq[1].val[31:0]}, {8'd1, 32'h5});
      chk("b2b_m2", {mq[2].core[7:0], mq[2].val[31:0]}, {8'd0, 32'h11});
    end

    do_reset();
    clr();
    ed.delete();
    em.delete();
    rr_m = 0;
    edrops = 0;
    for (int k = 0; k < 60; k++) begin
      nb    = ($urandom_range(0, 9) == 0) ? $urandom_range(185, 200)
                                          : $urandom_range(1, 10);
      bytes = $urandom_range(0, 7);
      err   = 1'($urandom);
      f0    = $urandom_range(180, 260);
      f1    = $urandom_range(180, 260);
      mf    = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      set_free(f0, f1);
      meta_full = mf;
      base = txd.size();
      send_frame(nb, bytes, err, 1'b1);
      model_frame(base, nb, bytes, err, f0, f1, mf);
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'($urandom);
        rx_sop   = 0;
        rx_eop   = 1'($urandom);
        rx_data  = {$urandom, $urandom};
        @(posedge clock);
        #1;
      end
      rx_valid = 0; rx_eop = 0;
    end
    idle(6);
    chk("rnd_ndata", dq.size(), ed.size());
    ok = (dq.size() == ed.size());
    for (int j = 0; j < dq.size() && j < ed.size(); j++)
      if (dq[j].core != ed[j].core || dq[j].val !== ed[j].val) ok = 0;
    chk("rnd_data", ok, 1);
    chk("rnd_nmeta", mq.size(), em.size());
    ok = (mq.size() == em.size());
    for (int j = 0; j < mq.size() && j < em.size(); j++)
      if (mq[j].core != em[j].core || mq[j].val !== em[j].val) ok = 0;
    chk("rnd_meta", ok, 1);
    chk("rnd_drops", drops, edrops);
    chk("onehot", onehot_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
